// File: rtl/prbs31_checker_if.sv
// Byte-stream input and checker status bundle for prbs31_checker; byte_cnt exists only with PRBS31_CHECKER_STATS_EN.
// Master drives the received byte stream and the counter clear; slave returns lock and error status.
interface prbs31_checker_if #(
    parameter int CNT_W = 16
);
    logic             in_valid;
    logic [7:0]       in_data;
    logic             clear_cnt;
    logic             locked;
    logic             err_pulse;
    logic [3:0]       err_bits;
    logic [CNT_W-1:0] err_cnt;
`ifdef PRBS31_CHECKER_STATS_EN
    logic [31:0]      byte_cnt;

    modport master (
        output in_valid, in_data, clear_cnt,
        input  locked, err_pulse, err_bits, err_cnt, byte_cnt
    );
    modport slave (
        input  in_valid, in_data, clear_cnt,
        output locked, err_pulse, err_bits, err_cnt, byte_cnt
    );
`else
    modport master (
        output in_valid, in_data, clear_cnt,
        input  locked, err_pulse, err_bits, err_cnt
    );
    modport slave (
        input  in_valid, in_data, clear_cnt,
        output locked, err_pulse, err_bits, err_cnt
    );
`endif
endinterface

// File: rtl/prbs31_checker.sv
// PRBS31 (x^31+x^28+1) byte checker: self-syncs, locks, counts bit errors; PRBS31_CHECKER_STATS_EN adds byte_cnt.
// Latency: status reflects a byte one cycle after it is sampled.
// Backpressure: none; always ready, state advances only on in_valid.
module prbs31_checker #(
    parameter int LOCK_BYTES = 4,
    parameter int LOSS_BYTES = 4,
    parameter int CNT_W      = 16
) (
    input logic             clk,
    input logic             rst_n,
    prbs31_checker_if.slave bus
);
    typedef enum logic {SEARCH = 1'b0, LOCKED = 1'b1} state_t;

    state_t           state_q, state_d;
    logic [30:0]      h_q, h_d;
    logic [4:0]       fill_q, fill_d;
    logic [3:0]       match_q, match_d;
    logic [3:0]       bad_q, bad_d;
    logic             err_pulse_q, err_pulse_d;
    logic [3:0]       err_bits_q, err_bits_d;
    logic [CNT_W-1:0] err_cnt_q, err_cnt_d;
    logic [CNT_W:0]   sum;
    logic [30:0]      ph;
    logic [7:0]       pred, diff;
    logic [3:0]       e;
`ifdef PRBS31_CHECKER_STATS_EN
    logic [31:0]      byte_cnt_q, byte_cnt_d;
`endif

    // Next 8 sequence bits from the history, earliest bit lands in pred[7].
    always_comb begin
        ph   = h_q;
        pred = '0;
        for (int i = 7; i >= 0; i--) begin
            pred[i] = ph[30] ^ ph[27];
            ph      = {ph[29:0], pred[i]};
        end
        diff = bus.in_data ^ pred;
        e    = '0;
        for (int i = 0; i < 8; i++) begin
            e = e + {3'b000, diff[i]};
        end
    end

    always_comb begin
        state_d     = state_q;
        h_d         = h_q;
        fill_d      = fill_q;
        match_d     = match_q;
        bad_d       = bad_q;
        err_pulse_d = 1'b0;
        err_bits_d  = err_bits_q;
        err_cnt_d   = err_cnt_q;
        sum         = '0;
`ifdef PRBS31_CHECKER_STATS_EN
        byte_cnt_d  = byte_cnt_q;
`endif
        // A clear wins over accumulation; a coincident locked byte then adds onto zero.
        if (bus.clear_cnt) begin
            err_cnt_d  = '0;
`ifdef PRBS31_CHECKER_STATS_EN
            byte_cnt_d = '0;
`endif
        end
        if (bus.in_valid) begin
            if (state_q == SEARCH) begin
                h_d    = {h_q[22:0], bus.in_data};
                fill_d = (fill_q > 5'd23) ? 5'd31 : fill_q + 5'd8;
                if (fill_q == 5'd31 && h_q != '0 && bus.in_data == pred) begin
                    match_d = match_q + 4'd1;
                end else begin
                    match_d = '0;
                end
                if (match_d == 4'(LOCK_BYTES)) begin
                    state_d = LOCKED;
                    match_d = '0;
                    bad_d   = '0;
                end
            end else begin
                // Locked: free-run on the prediction so line errors never enter the history.
                h_d         = {h_q[22:0], pred};
                err_bits_d  = e;
                err_pulse_d = (e != 4'd0);
                sum         = {1'b0, err_cnt_d} + (CNT_W+1)'(e);
                err_cnt_d   = sum[CNT_W] ? '1 : sum[CNT_W-1:0];
`ifdef PRBS31_CHECKER_STATS_EN
                byte_cnt_d  = byte_cnt_d + 32'd1;
`endif
                bad_d = (e != 4'd0) ? bad_q + 4'd1 : 4'd0;
                if (bad_d == 4'(LOSS_BYTES)) begin
                    state_d = SEARCH;
                    fill_d  = '0;
                    match_d = '0;
                    bad_d   = '0;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= SEARCH;
            h_q         <= '0;
            fill_q      <= '0;
            match_q     <= '0;
            bad_q       <= '0;
            err_pulse_q <= 1'b0;
            err_bits_q  <= '0;
            err_cnt_q   <= '0;
`ifdef PRBS31_CHECKER_STATS_EN
            byte_cnt_q  <= '0;
`endif
        end else begin
            state_q     <= state_d;
            h_q         <= h_d;
            fill_q      <= fill_d;
            match_q     <= match_d;
            bad_q       <= bad_d;
            err_pulse_q <= err_pulse_d;
            err_bits_q  <= err_bits_d;
            err_cnt_q   <= err_cnt_d;
`ifdef PRBS31_CHECKER_STATS_EN
            byte_cnt_q  <= byte_cnt_d;
`endif
        end
    end

    assign bus.locked    = (state_q == LOCKED);
    assign bus.err_pulse = err_pulse_q;
    assign bus.err_bits  = err_bits_q;
    assign bus.err_cnt   = err_cnt_q;
`ifdef PRBS31_CHECKER_STATS_EN
    assign bus.byte_cnt  = byte_cnt_q;
`endif
endmodule

// File: doc/prbs31_checker.md
Name: prbs31_checker

Overview:
- Receive-side companion to the PRBS31 generator. Consumes a byte-wide PRBS31 stream (x^31 + x^28 + 1) that has come back from the pads or from a loopback.
- Self-synchronises to the stream, declares lock, then counts bit errors against a locally predicted sequence.
- Sits directly downstream of the generator, typically fed from ui_in or uio_in, with status driven onto uo_out.

Parameters:
LOCK_BYTES, 4, consecutive matching bytes needed in SEARCH to declare lock (1..15)
LOSS_BYTES, 4, consecutive errored bytes in LOCKED that drop lock (1..15)
CNT_W, 16, width of the saturating bit-error counter (4..32)

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  in_data is a valid byte this cycle
in_data  input  8  received byte; bit7 is earliest in time
clear_cnt  input  1  synchronous clear of err_cnt
locked  output  1  checker is locked to the stream
err_pulse  output  1  one-cycle pulse per errored byte while locked
err_bits  output  4  bit errors (popcount) in the last byte checked while locked
err_cnt  output  CNT_W  saturating total of bit errors since reset or clear

Behaviour:
- Reset: async on rst_n low. All outputs, state, history and counters go to 0, and the state machine enters SEARCH.
- Sequence definition: b[n] = b[n-31] ^ b[n-28].
- History register h holds 31 bits, newest bit in h[0]. The predicted byte P is the next 8 bits generated from h by the recurrence, MSB first.
- State and counter updates happen only on cycles with in_valid=1. When in_valid=0, all state holds and err_pulse=0.
- All outputs are registered and reflect a byte one cycle after it is sampled.
- SEARCH:
  - Every received byte is shifted into h (received bits, not predicted ones).
  - fill counts received bits, saturating at 31.
  - Comparison is enabled only when fill==31 before the byte is shifted in, i.e. from the 5th byte onward, and h != 0.
  - Byte equals P with comparison enabled -> match_cnt+1. Otherwise match_cnt=0.
  - match_cnt reaches LOCK_BYTES -> go to LOCKED and set locked=1.
  - In SEARCH, err_pulse, err_bits and err_cnt do not change.
- LOCKED:
  - h shifts in P, not the received bits, so errors do not propagate.
  - e = popcount(in_data ^ P). err_bits=e. err_pulse=(e!=0).
  - err_cnt = min(err_cnt + e, 2^CNT_W - 1).
  - e!=0 -> bad_run+1. e==0 -> bad_run=0.
  - bad_run reaches LOSS_BYTES -> go to SEARCH: locked=0, fill=0, match_cnt=0, bad_run=0. err_cnt is retained.
  - The byte that causes loss of lock is still counted in err_cnt.
- clear_cnt:
  - Takes priority over accumulation. If it coincides with an errored byte, err_cnt = e of that byte (saturated).
  - clear_cnt with in_valid=0 -> err_cnt=0.
  - Has no effect on the state machine.
- All-zero stream never locks because of the h != 0 rule. An all-ones stream never matches after 4 bytes (ones xor ones = 0), so it also never locks.
- No other states. The state register is 1 bit: SEARCH=0, LOCKED=1.

Optional Feature:
- Macro: PRBS31_CHECKER_STATS_EN.
- When defined, adds output byte_cnt (32 bits). It counts valid bytes checked while LOCKED, wraps at 2^32, and is cleared by reset and by clear_cnt together with err_cnt.
- When undefined, the port and its counter are absent and behaviour is otherwise identical.

Test Plan:
- Clean lock: generator seeded h=0x7FFFFFFF, in_valid continuous, defaults.
  - Required: locked rises the cycle after byte 8 (4 fill + 4 match bytes).
  - Required: err_cnt stays 0 over 1000 bytes and err_pulse is never asserted.
- Single-bit error: after lock, XOR byte 20 with 0x01.
  - Required: err_pulse high for exactly 1 cycle, err_bits=1, err_cnt=1, locked stays 1.
  - Required: following clean bytes give err_bits=0.
- Burst loss: after lock, XOR 4 consecutive bytes with 0xFF.
  - Required: err_cnt=32 and locked=0 the cycle after the 4th byte.
  - Required: with clean stream resumed, re-lock 8 bytes later.
- All-zero input for 100 valid bytes -> locked stays 0. Gaps with in_valid=0 between bytes -> same lock timing, counted in valid bytes.
- Saturation and clear with CNT_W=4: inject 3 bytes with 8 errors each, LOSS_BYTES=15 -> err_cnt=15.
  - Then clear_cnt coincident with a 2-bit-error byte -> err_cnt=2.
- Reset mid-lock: pull rst_n low asynchronously between clock edges.
  - Required: all outputs 0 immediately.
  - Required: after release, locked rises only after 8 more clean bytes.
